// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Opcodes, FSM states and ALU operation codes for cpu_mc_core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_LWI   = 8'h09;
    localparam logic [7:0] OP_SWD   = 8'h0A;
    localparam logic [7:0] OP_SWI   = 8'h0B;
    localparam logic [7:0] OP_BNE   = 8'h0C;
    localparam logic [7:0] OP_SLL   = 8'h0D;
    localparam logic [7:0] OP_SRL   = 8'h0E;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_FWD = 3'd0,
        ALU_ADD = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SRL = 3'd5
    } aluop_t;

    typedef enum logic [1:0] {
        OPB_REG = 2'd0,
        OPB_NEG = 2'd1,
        OPB_IMM = 2'd2
    } opb_t;

    function automatic aluop_t alu_op_of(input logic [7:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_BEQ, OP_BNE: alu_op_of = ALU_ADD;
            OP_AND:                         alu_op_of = ALU_AND;
            OP_OR:                          alu_op_of = ALU_OR;
            OP_SLL:                         alu_op_of = ALU_SLL;
            OP_SRL:                         alu_op_of = ALU_SRL;
            default:                        alu_op_of = ALU_FWD;
        endcase
    endfunction

    function automatic opb_t opb_of(input logic [7:0] op);
        case (op)
            OP_LOADI, OP_LWI, OP_SWI, OP_SLL, OP_SRL: opb_of = OPB_IMM;
            OP_SUB, OP_BEQ, OP_BNE:                   opb_of = OPB_NEG;
            default:                                  opb_of = OPB_REG;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_p.sv
// ============================================================================
// Module  : reg_file_p
// Brief   : Register file, two asynchronous read ports, one synchronous write.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_p #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2
);

    logic [DATA_W-1:0] r_regs [2**REG_ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**REG_ADDR_W; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata1 = r_regs[raddr1];
    assign rdata2 = r_regs[raddr2];

endmodule

`default_nettype wire

// File: rtl/cpu_mc_core.sv
// ============================================================================
// Module  : cpu_mc_core
// Brief   : Multi-cycle 8-bit CPU core with handshaked instruction/data memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_mc_core
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int ADDR_W     = 8,
    parameter int PC_W       = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [PC_W-1:0]   PC,
    output logic              IREAD,
    input  logic [31:0]       INSTRUCTION,
    input  logic              IBUSYWAIT,
    output logic              READ,
    output logic              WRITE,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic [DATA_W-1:0] WRITEDATA,
    input  logic [DATA_W-1:0] READDATA,
    input  logic              BUSYWAIT,
    output logic              HALTED
);

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_ir;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_r;
    logic [DATA_W-1:0]   w_rd1;
    logic [DATA_W-1:0]   w_rd2;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_op2;
    logic [DATA_W-1:0]   w_alu;
    logic [DATA_W-1:0]   w_diff;
    logic [ADDR_W-1:0]   w_addr;
    logic [PC_W-1:0]     w_pc_seq;
    logic [PC_W-1:0]     w_off_ext;
    logic [PC_W-1:0]     w_pc_branch;
    logic [7:0]          w_opcode;
    logic                w_is_load;
    logic                w_is_store;
    logic                w_is_branch;
    logic                w_taken;
    logic                w_unused_bits;

    assign w_opcode      = r_ir[31:24];
    assign w_imm         = DATA_W'(r_ir[7:0]);
    assign w_is_load     = (w_opcode == OP_LWD) || (w_opcode == OP_LWI);
    assign w_is_store    = (w_opcode == OP_SWD) || (w_opcode == OP_SWI);
    assign w_is_branch   = (w_opcode == OP_BEQ) || (w_opcode == OP_BNE);
    assign w_diff        = r_a - r_b;
    assign w_taken       = (w_opcode == OP_J) ||
                           ((w_opcode == OP_BEQ) && (w_diff == '0)) ||
                           ((w_opcode == OP_BNE) && (w_diff != '0));
    assign w_pc_seq      = PC + PC_W'(4);
    assign w_off_ext     = PC_W'($signed(r_ir[23:16]));
    assign w_pc_branch   = w_pc_seq + {w_off_ext[PC_W-3:0], 2'b00};
    assign w_unused_bits = ^r_ir[15:8];

    reg_file_p #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regs (
        .clk    (CLK),
        .rst    (RESET),
        .we     (r_state == S_WB),
        .waddr  (r_ir[16 +: REG_ADDR_W]),
        .wdata  (r_r),
        .raddr1 (r_ir[8 +: REG_ADDR_W]),
        .raddr2 (r_ir[0 +: REG_ADDR_W]),
        .rdata1 (w_rd1),
        .rdata2 (w_rd2)
    );

    always_comb begin
        w_op2 = r_b;
        w_alu = '0;
        case (opb_of(w_opcode))
            OPB_IMM: w_op2 = w_imm;
            OPB_NEG: w_op2 = -r_b;
            default: w_op2 = r_b;
        endcase
        case (alu_op_of(w_opcode))
            ALU_ADD: w_alu = r_a + w_op2;
            ALU_AND: w_alu = r_a & w_op2;
            ALU_OR:  w_alu = r_a | w_op2;
            ALU_SLL: w_alu = r_a << w_op2[2:0];
            ALU_SRL: w_alu = r_a >> w_op2[2:0];
            default: w_alu = w_op2;
        endcase
    end

    generate
        if (ADDR_W <= DATA_W) begin : g_addr_trunc
            assign w_addr = w_alu[ADDR_W-1:0];
        end else begin : g_addr_zext
            assign w_addr = {{(ADDR_W-DATA_W){1'b0}}, w_alu};
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // IREAD is masked by RESET so no fetch is requested while reset is held.
    always_comb begin
        w_next = r_state;
        IREAD  = 1'b0;
        READ   = 1'b0;
        WRITE  = 1'b0;
        HALTED = 1'b0;
        case (r_state)
            S_FETCH: begin
                IREAD = ~RESET;
                if (!IBUSYWAIT) w_next = S_DECODE;
            end
            S_DECODE: w_next = (w_opcode > OP_SRL) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if ((w_opcode == OP_J) || w_is_branch) w_next = S_FETCH;
                else if (w_is_load || w_is_store)     w_next = S_MEM;
                else                                  w_next = S_WB;
            end
            S_MEM: begin
                READ  = w_is_load;
                WRITE = w_is_store;
                if (!BUSYWAIT) w_next = w_is_load ? S_WB : S_FETCH;
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  HALTED = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PC        <= '0;
            ADDRESS   <= '0;
            WRITEDATA <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_r       <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (!IBUSYWAIT) r_ir <= INSTRUCTION;
                S_DECODE: begin
                    r_a <= w_rd1;
                    r_b <= w_rd2;
                end
                S_EXEC: begin
                    r_r <= w_alu;
                    if (w_taken)          PC <= w_pc_branch;
                    else if (w_is_branch) PC <= w_pc_seq;
                    if (w_is_load || w_is_store) begin
                        ADDRESS   <= w_addr;
                        WRITEDATA <= r_a;
                    end
                end
                S_MEM: begin
                    if (!BUSYWAIT) begin
                        if (w_is_load) r_r <= READDATA;
                        else           PC  <= w_pc_seq;
                    end
                end
                S_WB:    PC <= w_pc_seq;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_mc_core.sv
// ============================================================================
// Module  : tb_cpu_mc_core
// Brief   : Directed self-checking bench for cpu_mc_core with wait-state memories.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_mc_core;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] PC;
    logic        IREAD;
    logic [31:0] INSTRUCTION;
    logic        IBUSYWAIT;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        HALTED;

    cpu_mc_core #(
        .DATA_W     (8),
        .REG_ADDR_W (3),
        .ADDR_W     (8),
        .PC_W       (32)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PC          (PC),
        .IREAD       (IREAD),
        .INSTRUCTION (INSTRUCTION),
        .IBUSYWAIT   (IBUSYWAIT),
        .READ        (READ),
        .WRITE       (WRITE),
        .ADDRESS     (ADDRESS),
        .WRITEDATA   (WRITEDATA),
        .READDATA    (READDATA),
        .BUSYWAIT    (BUSYWAIT),
        .HALTED      (HALTED)
    );

    always #5 CLK = ~CLK;

    logic [31:0] imem [64];
    logic [7:0]  dmem [256];
    int          iwait = 0;
    int          dwait = 0;
    int          icnt = 0;
    int          dcnt = 0;
    int          wr_cnt = 0;
    int          proto_err = 0;
    int          checks = 0;
    int          failures = 0;

    assign INSTRUCTION = imem[PC[7:2]];
    assign IBUSYWAIT   = IREAD && (icnt < iwait);
    assign BUSYWAIT    = (READ || WRITE) && (dcnt < dwait);

    always @(posedge CLK) begin
        icnt <= (IREAD && IBUSYWAIT) ? icnt + 1 : 0;
        dcnt <= ((READ || WRITE) && BUSYWAIT) ? dcnt + 1 : 0;
        if (WRITE && !BUSYWAIT) begin
            dmem[ADDRESS] <= WRITEDATA;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    always @(negedge CLK) begin
        if ((READ && WRITE) || (IREAD && (READ || WRITE))) proto_err <= proto_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_imem;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0000;
    endtask

    task automatic hold_reset;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    // Waits for READ (want_write=0) or WRITE (want_write=1); k = negedges seen.
    task automatic wait_req(input bit want_write, input int budget, output int k);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!(want_write ? WRITE : READ) && k < budget);
    endtask

    task automatic wait_fetch_change(input logic [31:0] prev, input int budget, output int k);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!(IREAD && PC != prev) && k < budget);
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        int k = 0;
        while (wr_cnt < target && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check(tag, 32'(wr_cnt >= target), 32'd1);
    endtask

    initial begin
        int k;
        int rd_cycles;
        int bad;
        int base;
        logic [7:0] rd_addr;

        READDATA = 8'h00;
        clear_imem();

        // Test 1: loadi/loadi/add/swi, reset state first.
        imem[0] = 32'h0001_0005;
        imem[1] = 32'h0002_0003;
        imem[2] = 32'h0203_0102;
        imem[3] = 32'h0B00_0310;
        hold_reset();
        check("rst_pc", PC, 32'h0);
        check("rst_req", {28'h0, IREAD, READ, WRITE, HALTED}, 32'h0);
        check("rst_addr_wdata", {16'h0, ADDRESS, WRITEDATA}, 32'h0);
        RESET = 1'b0;
        wait_req(1'b1, 60, k);
        check("t1_write", WRITE, 1'b1);
        check("t1_latency", k, 32'd15);
        check("t1_addr", ADDRESS, 8'h10);
        check("t1_wdata", WRITEDATA, 8'h08);
        check("t1_no_iread", IREAD, 1'b0);
        @(negedge CLK);
        check("t1_next_pc", {IREAD, PC[30:0]}, {1'b1, 31'h10});

        // Test 2: sub wraps, swd addresses by rs2, two instruction wait states.
        clear_imem();
        imem[0] = 32'h0001_0003;
        imem[1] = 32'h0002_0005;
        imem[2] = 32'h0303_0102;
        imem[3] = 32'h0A00_0301;
        iwait = 2;
        hold_reset();
        RESET = 1'b0;
        wait_req(1'b1, 80, k);
        check("t2_latency", k, 32'd23);
        check("t2_addr", ADDRESS, 8'h03);
        check("t2_wdata", WRITEDATA, 8'hFE);
        iwait = 0;

        // Test 3: j to 0x20 then beq taken backwards.
        clear_imem();
        imem[0] = 32'h0607_0000;
        imem[8] = 32'h07FE_0101;
        hold_reset();
        RESET = 1'b0;
        wait_fetch_change(32'h0, 20, k);
        check("t3_j_pc", PC, 32'h20);
        check("t3_j_latency", k, 32'd3);
        wait_fetch_change(32'h20, 20, k);
        check("t3_beq_pc", PC, 32'h1C);
        check("t3_beq_latency", k, 32'd3);

        imem[8] = 32'h0CFE_0101;
        hold_reset();
        RESET = 1'b0;
        wait_fetch_change(32'h0, 20, k);
        wait_fetch_change(32'h20, 20, k);
        check("t3_bne_pc", PC, 32'h24);

        // Test 4: lwi with three data wait states, then store the loaded value.
        clear_imem();
        imem[0] = 32'h0904_0040;
        imem[1] = 32'h0B00_0455;
        dwait = 3;
        READDATA = 8'hA5;
        hold_reset();
        base = wr_cnt;
        RESET = 1'b0;
        rd_cycles = 0;
        rd_addr = 8'h00;
        k = 0;
        while (wr_cnt < base + 1 && k < 60) begin
            @(negedge CLK);
            k++;
            if (READ) begin
                rd_cycles++;
                rd_addr = ADDRESS;
            end
        end
        check("t4_store_done", 32'(wr_cnt >= base + 1), 32'd1);
        check("t4_read_cycles", rd_cycles, 32'd4);
        check("t4_read_addr", rd_addr, 8'h40);
        check("t4_r4", dmem[8'h55], 8'hA5);
        dwait = 0;

        // ALU coverage: sll, srl, and, or, mov, add with rd == rs1.
        clear_imem();
        imem[0]  = 32'h0001_00B4;
        imem[1]  = 32'h0D02_0103;
        imem[2]  = 32'h0E03_0102;
        imem[3]  = 32'h0404_0103;
        imem[4]  = 32'h0505_0203;
        imem[5]  = 32'h0106_0005;
        imem[6]  = 32'h0201_0101;
        imem[7]  = 32'h0B00_0221;
        imem[8]  = 32'h0B00_0322;
        imem[9]  = 32'h0B00_0423;
        imem[10] = 32'h0B00_0624;
        imem[11] = 32'h0B00_0125;
        hold_reset();
        base = wr_cnt;
        RESET = 1'b0;
        wait_writes(base + 5, 200, "alu_done");
        check("alu_sll", dmem[8'h21], 8'hA0);
        check("alu_srl", dmem[8'h22], 8'h2D);
        check("alu_and", dmem[8'h23], 8'h24);
        check("alu_mov_or", dmem[8'h24], 8'hAD);
        check("alu_add_self", dmem[8'h25], 8'h68);

        // Test 5: illegal opcode halts, PC frozen, reset recovers.
        clear_imem();
        imem[0] = 32'hFF00_0000;
        hold_reset();
        RESET = 1'b0;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!HALTED && k < 10);
        check("t5_halt_latency", k, 32'd2);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (PC != 32'h0 || !HALTED || IREAD || READ || WRITE) bad++;
        end
        check("t5_frozen", bad, 32'd0);
        RESET = 1'b1;
        @(negedge CLK);
        check("t5_rst_halted", HALTED, 1'b0);
        check("t5_rst_pc", PC, 32'h0);

        // Test 6: reset during a stalled load abandons it.
        clear_imem();
        imem[0] = 32'h0904_0040;
        dwait = 100;
        hold_reset();
        RESET = 1'b0;
        wait_req(1'b0, 20, k);
        check("t6_read_latency", k, 32'd3);
        @(negedge CLK);
        @(negedge CLK);
        check("t6_read_held", READ, 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        check("t6_read_dropped", READ, 1'b0);
        check("t6_pc", PC, 32'h0);
        check("t6_iread_in_reset", IREAD, 1'b0);
        RESET = 1'b0;
        #1;
        check("t6_iread_after", IREAD, 1'b1);
        dwait = 0;

        check("protocol", proto_err, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
